// File: rtl/fwd_ctrl.sv
// Forwarding / hazard controller beside the ID/EX register: picks operand forward
// selects from a 3-deep destination history and raises load-use / branch-compare stalls.
// Optional feature macro: FWD_LOAD_USE_STALL_EN (enables the load-use stall).
module fwd_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [2:0] id_opa_base,
    input  logic [2:0] id_opb_base,
    input  logic       id_cond_branch,
    input  logic [4:0] id_rd,
    input  logic       id_rd_we,
    input  logic       id_is_load,
    input  logic       ex_take_branch,
    output logic [2:0] id_ex_opa_select,
    output logic [2:0] id_ex_opb_select,
    output logic       id_ex_valid_inst,
    output logic       stall
);

    // Select encodings shared with the execute-stage operand muxes.
    localparam logic [2:0] ALU_OPA_IS_REGA = 3'd0;
    localparam logic [2:0] ALU_OPA_IS_PC   = 3'd1;
    localparam logic [2:0] ALU_OPA_IS_ZR   = 3'd2;
    localparam logic [2:0] ALU_OPB_IS_REGB = 3'd0;
    localparam logic [2:0] ALU_OPB_IS_IMM  = 3'd1;
    localparam logic [2:0] ALU_OPB_IS_4    = 3'd2;
    localparam logic [2:0] FOWARD_1        = 3'd4;
    localparam logic [2:0] FOWARD_2        = 3'd5;
    localparam logic [2:0] FOWARD_3        = 3'd6;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
    } hist_t;

    // Index 0 = EX (h1), 1 = MEM (h2), 2 = WB (h3).
    hist_t [2:0] hist_q, hist_d;
    logic  [2:0] opa_sel_q, opa_sel_d;
    logic  [2:0] opb_sel_q, opb_sel_d;
    logic        valid_inst_q, valid_inst_d;

    logic  [2:0] match_a, match_b;
    logic  [2:0] opa_fwd, opb_fwd;
    logic        br_stall, load_use, stall_int;

    function automatic logic hmatch(input hist_t h, input logic [4:0] r);
        return h.valid && h.we && (h.rd == r) && (r != 5'd0);
    endfunction

    function automatic logic [2:0] pick_fwd(input logic [2:0] m, input logic [2:0] base);
        logic [2:0] sel;
        sel = base;
        if (m[0])      sel = FOWARD_1;
        else if (m[1]) sel = FOWARD_2;
        else if (m[2]) sel = FOWARD_3;
        return sel;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            match_a[i] = hmatch(hist_q[i], id_rs1);
            match_b[i] = hmatch(hist_q[i], id_rs2);
        end
        opa_fwd = (id_opa_base == ALU_OPA_IS_REGA) ? pick_fwd(match_a, id_opa_base) : id_opa_base;
        opb_fwd = (id_opb_base == ALU_OPB_IS_REGB) ? pick_fwd(match_b, id_opb_base) : id_opb_base;
        // Branch compare reads unforwarded register values, so any in-flight writer blocks it.
        br_stall = id_cond_branch && ((|match_a) || (|match_b));
    end

`ifdef FWD_LOAD_USE_STALL_EN
    logic h1_load_q, h1_load_d;
    logic use_a, use_b;

    always_comb begin
        use_a    = (id_opa_base == ALU_OPA_IS_REGA) || id_cond_branch;
        use_b    = (id_opb_base == ALU_OPB_IS_REGB) || id_cond_branch;
        load_use = h1_load_q && ((use_a && match_a[0]) || (use_b && match_b[0]));
    end

    always_comb begin
        h1_load_d = 1'b0;
        if (!ex_take_branch && !stall_int)
            h1_load_d = id_is_load;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) h1_load_q <= 1'b0;
        else      h1_load_q <= h1_load_d;
    end
`else
    logic unused_load;
    assign unused_load = id_is_load;
    assign load_use    = 1'b0;
`endif

    // Flush suppresses the stall: the ID instruction is being discarded anyway.
    assign stall_int = id_valid && !ex_take_branch && (load_use || br_stall);
    assign stall     = stall_int && rst;

    always_comb begin
        hist_d[2] = hist_q[1];
        hist_d[1] = hist_q[0];
        if (ex_take_branch || stall_int) begin
            hist_d[0]    = '0;
            opa_sel_d    = ALU_OPA_IS_REGA;
            opb_sel_d    = ALU_OPB_IS_REGB;
            valid_inst_d = 1'b0;
        end else begin
            hist_d[0]    = '{valid: id_valid, rd: id_rd, we: id_rd_we};
            opa_sel_d    = opa_fwd;
            opb_sel_d    = opb_fwd;
            valid_inst_d = id_valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q       <= '0;
            opa_sel_q    <= ALU_OPA_IS_REGA;
            opb_sel_q    <= ALU_OPB_IS_REGB;
            valid_inst_q <= 1'b0;
        end else begin
            hist_q       <= hist_d;
            opa_sel_q    <= opa_sel_d;
            opb_sel_q    <= opb_sel_d;
            valid_inst_q <= valid_inst_d;
        end
    end

    assign id_ex_opa_select = opa_sel_q;
    assign id_ex_opb_select = opb_sel_q;
    assign id_ex_valid_inst = valid_inst_q;

    logic unused_enc;
    assign unused_enc = ^{ALU_OPA_IS_PC, ALU_OPA_IS_ZR, ALU_OPB_IS_IMM, ALU_OPB_IS_4};

endmodule
